// File: rtl/carbonio_irq_dispatcher.sv
// carbonio_irq_dispatcher
// Sink side of the CarbonIO IRQ router. Converts the router's valid/vector into
// a CPU request / INTA / EOI handshake, returns a one-cycle ack carrying the
// serviced index, and tracks a single in-service source (no nesting).
module carbonio_irq_dispatcher #(
    parameter int          N_SOURCES   = 8,
    parameter int          VEC_W       = (N_SOURCES <= 1) ? 1 : $clog2(N_SOURCES),
    parameter logic [7:0]  VEC_BASE    = 8'h00,
    parameter int          VEC_STRIDE  = 2,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 global_en,
    input  logic                 irq_valid,
    input  logic [VEC_W-1:0]     irq_vector,
    output logic                 irq_ack,
    output logic [VEC_W-1:0]     irq_ack_vector,
    output logic                 cpu_irq,
    input  logic                 cpu_inta,
    output logic [7:0]           cpu_vec,
    output logic                 cpu_vec_valid,
    input  logic                 cpu_eoi,
    output logic [N_SOURCES-1:0] in_service,
    output logic                 busy,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    // Counter only has to reach ACK_TIMEOUT-1; keep one bit when disabled.
    localparam int CNT_W = (ACK_TIMEOUT <= 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [VEC_W-1:0]       r_vec;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_irq_ack;
    logic [VEC_W-1:0]       r_ack_vec;
    logic                   r_cpu_irq;
    logic [7:0]             r_cpu_vec;
    logic                   r_cpu_vec_valid;
    logic [N_SOURCES-1:0]   r_in_service;
    logic                   r_busy;
    logic                   r_timeout_err;

    logic [7:0]             w_vec_byte;
    logic [N_SOURCES-1:0]   w_onehot;

    // Vector byte wraps modulo 256 by construction of the 8-bit arithmetic.
    assign w_vec_byte = VEC_BASE + (8'(r_vec) * 8'(VEC_STRIDE));
    assign w_onehot   = N_SOURCES'(1) << r_vec;

    // Request/grant/service sequencer; every output is registered here so
    // state-qualified outputs are set on the transition into that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_vec           <= '0;
            r_cnt           <= '0;
            r_irq_ack       <= 1'b0;
            r_ack_vec       <= '0;
            r_cpu_irq       <= 1'b0;
            r_cpu_vec       <= '0;
            r_cpu_vec_valid <= 1'b0;
            r_in_service    <= '0;
            r_busy          <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            // Single-cycle pulses default low; ack vector is zero when not acking.
            r_irq_ack       <= 1'b0;
            r_ack_vec       <= '0;
            r_cpu_vec_valid <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (err_clr)
                r_timeout_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (global_en && irq_valid) begin
                        r_vec     <= irq_vector;
                        r_cnt     <= '0;
                        r_cpu_irq <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (cpu_inta) begin
                        // Vector frozen; ack is issued even if the source just dropped.
                        r_irq_ack       <= 1'b1;
                        r_ack_vec       <= r_vec;
                        r_cpu_vec       <= w_vec_byte;
                        r_cpu_vec_valid <= 1'b1;
                        r_cpu_irq       <= 1'b0;
                        r_state         <= GRANT;
                    end else begin
                        // Track the router's current highest-priority source.
                        r_vec <= irq_vector;
                        if (!irq_valid || !global_en) begin
                            r_cpu_irq <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end else if (ACK_TIMEOUT != 0 && r_cnt == CNT_LAST) begin
                            r_timeout_err <= 1'b1;
                            r_cpu_irq     <= 1'b0;
                            r_busy        <= 1'b0;
                            r_state       <= IDLE;
                        end else if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                GRANT: begin
                    r_in_service <= w_onehot;
                    r_state      <= SERVICE;
                end
                SERVICE: begin
                    if (cpu_eoi) begin
                        r_in_service <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign irq_ack        = r_irq_ack;
    assign irq_ack_vector = r_ack_vec;
    assign cpu_irq        = r_cpu_irq;
    assign cpu_vec        = r_cpu_vec;
    assign cpu_vec_valid  = r_cpu_vec_valid;
    assign in_service     = r_in_service;
    assign busy           = r_busy;
    assign timeout_err    = r_timeout_err;

endmodule

// File: doc/carbonio_irq_dispatcher.md
Name: carbonio_irq_dispatcher

Overview:
- Downstream consumer of the CarbonIO IRQ router's irq_if sink side.
- Turns the router's valid/vector into a CPU-style request/acknowledge/EOI sequence and returns a one-cycle irq_ack with the serviced vector, which clears the router's pending bit.
- Computes an 8-bit CPU vector byte as base + index*stride and tracks a single-level in-service source.

Parameters:
- N_SOURCES, 8: number of interrupt sources; must match the router.
- VEC_W, (N_SOURCES<=1)?1:$clog2(N_SOURCES): vector index width (derived).
- VEC_BASE, 8'h00: base of the CPU vector byte.
- VEC_STRIDE, 2: vector byte spacing per source index.
- ACK_TIMEOUT, 255: REQ cycles allowed before abandoning; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- global_en  in  1  dispatcher enable.
- irq_valid  in  1  router has an active (pending & enabled) source.
- irq_vector  in  VEC_W  router's highest-priority active index.
- irq_ack  out  1  one-cycle acknowledge to the router.
- irq_ack_vector  out  VEC_W  index being acknowledged.
- cpu_irq  out  1  interrupt request to the CPU.
- cpu_inta  in  1  CPU acknowledge strobe, single cycle.
- cpu_vec  out  8  vector byte for the CPU.
- cpu_vec_valid  out  1  one-cycle qualifier for cpu_vec.
- cpu_eoi  in  1  CPU end-of-interrupt strobe.
- in_service  out  N_SOURCES  one-hot in-service source.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky acknowledge-timeout flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - state=IDLE.
  - All outputs 0, including cpu_vec, in_service and timeout_err.
  - vec_q=0, timeout counter=0.
  - rst overrides every other input in the same cycle, including mid-REQ or mid-SERVICE.
- All outputs are registered.
- IDLE:
  - If global_en & irq_valid: vec_q<=irq_vector, count<=0, go to REQ.
  - cpu_irq rises in the cycle after irq_valid is first sampled (1-cycle latency).
- REQ:
  - cpu_irq=1.
  - While cpu_inta=0, vec_q re-latches irq_vector every cycle, so it tracks priority changes in the router.
  - If cpu_inta=1: vec_q frozen, go to GRANT.
  - Else if !irq_valid or !global_en: withdraw to IDLE. cpu_irq drops the next cycle; no ack is issued.
  - Else if ACK_TIMEOUT!=0 and count==ACK_TIMEOUT-1: timeout_err<=1, go to IDLE with no ack.
  - Otherwise count increments. Counter width is clog2(ACK_TIMEOUT+1) and it does not wrap.
  - Priority order: cpu_inta, then withdraw, then timeout.
- GRANT (exactly one cycle):
  - irq_ack=1, irq_ack_vector=vec_q.
  - cpu_vec_valid=1, cpu_vec = (VEC_BASE + vec_q*VEC_STRIDE) mod 256 (truncated to 8 bits).
  - in_service<=one-hot(vec_q).
  - cpu_irq=0.
  - Next state: SERVICE.
  - cpu_vec holds its value until the next GRANT.
- SERVICE:
  - cpu_irq=0; new router requests are held off (single level, no nesting).
  - On cpu_eoi: in_service<=0, go to IDLE.
- Ignored inputs:
  - cpu_inta outside REQ.
  - cpu_eoi outside SERVICE.
- Simultaneous events:
  - inta and irq_valid falling in the same REQ cycle: the ack is still issued; the router tolerates an ack of a cleared bit.
  - Timeout set and err_clr in the same cycle: set wins.
  - eoi and a new irq_valid in the same cycle: go to IDLE first; the new request is taken on the following cycle.
- irq_ack_vector=0 whenever irq_ack=0.

Test Plan:
1. Basic acknowledge:
   - Stimulus: global_en=1; irq_vector=3 with irq_valid asserted at cycle N; cpu_inta pulse at N+3; cpu_eoi at N+8.
   - Response: cpu_irq=1 at N+1..N+3; at N+4, irq_ack=1, irq_ack_vector=3, cpu_vec=0x06, cpu_vec_valid=1; in_service=0x08 from N+5.
   - After eoi: in_service=0, busy=0.
2. Withdraw:
   - Stimulus: irq_valid=1 for 2 cycles, then 0 before any inta.
   - Response: cpu_irq deasserts the next cycle, no irq_ack, state IDLE; a later inta is ignored.
3. Timeout:
   - Stimulus: ACK_TIMEOUT=4, irq_valid held, no inta.
   - Response: after 4 REQ cycles timeout_err=1, cpu_irq=0, busy=0. A new request re-enters REQ. err_clr clears the flag, except when it coincides with a new timeout set.
4. Priority tracking:
   - Stimulus: irq_vector=5, then 2 before cpu_inta.
   - Response: irq_ack_vector=2, in_service=0x04.
5. Vector wrap:
   - Stimulus: VEC_BASE=8'hF8, VEC_STRIDE=4, vector 3.
   - Response: cpu_vec=0x04.
6. Reset mid-operation:
   - Stimulus: assert rst during SERVICE, and separately during REQ.
   - Response: next cycle all outputs 0, state IDLE, in_service=0; timeout_err cleared.
